cmult_arbiter: RTL and testbench

- Shares one pipelined complex multiplier between two requesters, e.g. two radix-2 butterfly stages that each need twiddle × sample products.
- Uses round-robin arbitration at burst granularity. A grant is held until the requester's last beat, or until an idle timeout expires.
- Registers the operands into the shared multiplier and tracks in-flight products with a tag pipeline, so each result is steered back to the requester that issued it.

---
 rtl/cmult_arbiter.sv | 138 +++++++++++++
 tb/tb_cmult_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cmult_arbiter.sv
`default_nettype none
// cmult_arbiter: burst-granular two-requester arbiter for one shared pipelined complex multiplier.
// Optional macro CMULT_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no rr_ptr). Rev 1.0
module cmult_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MULT_LAT = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_last,
  input  logic [DATA_W-1:0]   req0_tw_r,
  input  logic [DATA_W-1:0]   req0_tw_c,
  input  logic [DATA_W-1:0]   req0_d_r,
  input  logic [DATA_W-1:0]   req0_d_c,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic                req1_last,
  input  logic [DATA_W-1:0]   req1_tw_r,
  input  logic [DATA_W-1:0]   req1_tw_c,
  input  logic [DATA_W-1:0]   req1_d_r,
  input  logic [DATA_W-1:0]   req1_d_c,
  output logic                req1_ready,
  output logic [DATA_W-1:0]   m_ra,
  output logic [DATA_W-1:0]   m_ca,
  output logic [DATA_W-1:0]   m_rb,
  output logic [DATA_W-1:0]   m_cb,
  input  logic [2*DATA_W:0]   m_r,
  input  logic [2*DATA_W:0]   m_c,
  output logic                res0_valid,
  output logic                res1_valid,
  output logic [2*DATA_W:0]   res_r,
  output logic [2*DATA_W:0]   res_c,
  output logic                busy,
  output logic                err_timeout
);

  localparam int LAT = 1 + MULT_LAT;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t          state;
  logic [7:0]      tmo_cnt;
  logic [LAT-1:0]  tag_vld;
  logic [LAT-1:0]  tag_id;
  logic            acc0, acc1, acc, acc_last, tmo_hit, pick1;

  assign req0_ready = (state == OWN0);
  assign req1_ready = (state == OWN1);
  assign acc0       = req0_ready & req0_valid;
  assign acc1       = req1_ready & req1_valid;
  assign acc        = acc0 | acc1;
  assign acc_last   = (acc0 & req0_last) | (acc1 & req1_last);
  assign tmo_hit    = (state != IDLE) & ~acc & (tmo_cnt == 8'(TIMEOUT - 1));

`ifdef CMULT_ARB_FIXED_PRIO_EN
  assign pick1 = req1_valid & ~req0_valid;
`else
  logic rr_ptr;
  assign pick1 = req1_valid & (~req0_valid | rr_ptr);

  // Pointer moves to the other requester whenever a grant ends, by last beat or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if ((acc & acc_last) | tmo_hit)
      rr_ptr <= (state == OWN0);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= 8'd0;
          if (req0_valid | req1_valid)
            state <= pick1 ? OWN1 : OWN0;
        end
        OWN0, OWN1: begin
          if (acc) begin
            tmo_cnt <= 8'd0;
            if (acc_last)
              state <= IDLE;
          end else if (tmo_hit) begin
            tmo_cnt     <= 8'd0;
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ra <= '0;
      m_ca <= '0;
      m_rb <= '0;
      m_cb <= '0;
    end else if (acc) begin
      m_ra <= acc1 ? req1_tw_r : req0_tw_r;
      m_ca <= acc1 ? req1_tw_c : req0_tw_c;
      m_rb <= acc1 ? req1_d_r  : req0_d_r;
      m_cb <= acc1 ? req1_d_c  : req0_d_c;
    end
  end

  // Tag stage LAT-1 lines up with the product emerging from the external multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= acc;
      tag_id[0]  <= acc1;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign res0_valid = tag_vld[LAT-1] & ~tag_id[LAT-1];
  assign res1_valid = tag_vld[LAT-1] &  tag_id[LAT-1];
  assign res_r      = m_r;
  assign res_c      = m_c;
  assign busy       = (state != IDLE) | (|tag_vld);

endmodule
`default_nettype wire

// File: tb/tb_cmult_arbiter.sv
`default_nettype none
// tb_cmult_arbiter: directed self-checking bench for cmult_arbiter with a one-cycle multiplier model.
module tb_cmult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_last = 1'b0;
  logic [15:0] req0_tw_r = '0, req0_tw_c = '0, req0_d_r = '0, req0_d_c = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0, req1_last = 1'b0;
  logic [15:0] req1_tw_r = '0, req1_tw_c = '0, req1_d_r = '0, req1_d_c = '0;
  logic        req1_ready;
  logic [15:0] m_ra, m_ca, m_rb, m_cb;
  logic [32:0] m_r, m_c;
  logic        res0_valid, res1_valid;
  logic [32:0] res_r, res_c;
  logic        busy, err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmult_arbiter #(.DATA_W(16), .MULT_LAT(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_last(req0_last),
    .req0_tw_r(req0_tw_r), .req0_tw_c(req0_tw_c), .req0_d_r(req0_d_r), .req0_d_c(req0_d_c),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last),
    .req1_tw_r(req1_tw_r), .req1_tw_c(req1_tw_c), .req1_d_r(req1_d_r), .req1_d_c(req1_d_c),
    .req1_ready(req1_ready),
    .m_ra(m_ra), .m_ca(m_ca), .m_rb(m_rb), .m_cb(m_cb),
    .m_r(m_r), .m_c(m_c),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res_r(res_r), .res_c(res_c),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Single-cycle complex multiplier: (ra + j ca) * (rb + j cb).
  logic signed [32:0] xa_r, xa_c, xb_r, xb_c;
  assign xa_r = {{17{m_ra[15]}}, m_ra};
  assign xa_c = {{17{m_ca[15]}}, m_ca};
  assign xb_r = {{17{m_rb[15]}}, m_rb};
  assign xb_c = {{17{m_cb[15]}}, m_cb};
  always @(posedge clk) begin
    m_r <= xa_r * xb_r - xa_c * xb_c;
    m_c <= xa_r * xb_c + xa_c * xb_r;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected-result pipeline used during the round-robin run.
  logic        ev [2];
  logic        eid[2];
  int          ek [2];
  int          b0, b1;
  logic [1:0]  exp_rdy;
  logic        a0, a1;

  initial begin
    ev[0] = 1'b0; ev[1] = 1'b0; eid[0] = 1'b0; eid[1] = 1'b0; ek[0] = 0; ek[1] = 0;
    b0 = 0; b1 = 0;

    // Reset state
    tick();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_mra", m_ra, 0);
    chk("rst_res0", res0_valid, 0);
    rst = 1'b0;

    // Basic single-beat product for requester 0
    req0_valid = 1'b1; req0_last = 1'b1;
    req0_tw_r = 16'd3; req0_tw_c = 16'd4; req0_d_r = 16'd5; req0_d_c = 16'hFFFE;
    tick();
    chk("basic_rdy0", req0_ready, 1);
    chk("basic_rdy1", req1_ready, 0);
    chk("basic_busy", busy, 1);
    tick();
    req0_valid = 1'b0; req0_last = 1'b0;
    chk("basic_idle", req0_ready, 0);
    chk("basic_mra", m_ra, 3);
    chk("basic_mca", m_ca, 4);
    chk("basic_mcb", m_cb, 16'hFFFE);
    chk("basic_res0_early", res0_valid, 0);
    tick();
    chk("basic_res0", res0_valid, 1);
    chk("basic_res1", res1_valid, 0);
    chk("basic_res_r", $signed(res_r), 23);
    chk("basic_res_c", $signed(res_c), 14);
    tick();
    chk("basic_res0_gone", res0_valid, 0);
    chk("basic_res1_none", res1_valid, 0);
    chk("basic_busy_end", busy, 0);

    // Fresh reset so round-robin starts from requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin: both always valid, 3-beat bursts
    for (int i = 0; i < 20; i++) begin
      exp_rdy = ((i % 4 == 0) || (i > 16)) ? 2'b00 : (((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_ready", {req1_ready, req0_ready}, exp_rdy);
      chk("rr_res0", res0_valid, ev[1] & ~eid[1]);
      chk("rr_res1", res1_valid, ev[1] & eid[1]);
      if (ev[1]) begin
        chk("rr_res_r", $signed(res_r), ek[1]);
        chk("rr_res_c", $signed(res_c), 1);
      end
      req0_valid = (i < 16); req0_last = (b0 % 3 == 2);
      req0_tw_r = 16'(10 + b0); req0_tw_c = 16'd1; req0_d_r = 16'd1; req0_d_c = 16'd0;
      req1_valid = (i < 16); req1_last = (b1 % 3 == 2);
      req1_tw_r = 16'(40 + b1); req1_tw_c = 16'd1; req1_d_r = 16'd1; req1_d_c = 16'd0;
      a0 = req0_ready & req0_valid;
      a1 = req1_ready & req1_valid;
      ev[1] = ev[0]; eid[1] = eid[0]; ek[1] = ek[0];
      ev[0] = a0 | a1; eid[0] = a1; ek[0] = a1 ? (40 + b1) : (10 + b0);
      if (a0) b0++;
      if (a1) b1++;
      tick();
    end
    chk("rr_beats0", b0, 6);
    chk("rr_beats1", b1, 6);

    // Stall inside a requester-1 burst
    req1_valid = 1'b1; req1_last = 1'b0;
    tick();
    chk("stall_grant", req1_ready, 1);
    req0_valid = 1'b1; req0_last = 1'b1;
    tick();
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rdy1", req1_ready, 1);
      chk("stall_rdy0", req0_ready, 0);
      chk("stall_err", err_timeout, 0);
    end
    req1_valid = 1'b1; req1_last = 1'b1;
    tick();
    req1_valid = 1'b0; req1_last = 1'b0;
    chk("stall_end_rdy1", req1_ready, 0);
    chk("stall_end_err", err_timeout, 0);
    tick();
    chk("stall_next_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0; req0_last = 1'b0;
    tick();
    tick();

    // Timeout: requester 0 stalls after one beat while requester 1 waits
    req0_valid = 1'b1; req0_last = 1'b0;
    tick();
    chk("tmo_grant", req0_ready, 1);
    req1_valid = 1'b1; req1_last = 1'b1;
    tick();
    req0_valid = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("tmo_hold", req0_ready, 1);
      chk("tmo_err_low", err_timeout, 0);
    end
    tick();
    chk("tmo_rdy0", req0_ready, 0);
    chk("tmo_rdy1_idle", req1_ready, 0);
    chk("tmo_err", err_timeout, 1);
    tick();
    chk("tmo_next_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0; req1_last = 1'b0;
    chk("tmo_err_sticky", err_timeout, 1);
    tick();

    // Reset mid-burst
    req0_valid = 1'b1; req0_last = 1'b0;
    req0_tw_r = 16'd7; req0_tw_c = 16'd2; req0_d_r = 16'd3; req0_d_c = 16'd1;
    tick();
    tick();
    chk("mid_mra", m_ra, 7);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy0", req0_ready, 0);
    chk("mid_rst_mra", m_ra, 0);
    chk("mid_rst_mcb", m_cb, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_timeout, 0);
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_res0", res0_valid, 0);
      chk("mid_no_res1", res1_valid, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
